// File: rtl/vmm_pkg.sv
// Shared types and constants for the word serializer and its FIFO.
package vmm_pkg;

  localparam int WORD_W = 32;

  // Serializer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with a registered head-of-queue output.
// dout_o always holds the oldest stored word, so a consumer can pop and
// use the data on the same edge.
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic [AW-1:0]    rd_nxt_idx;
  logic             push_ok, pop_ok;

  // The extra pointer MSB distinguishes a full FIFO from an empty one.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign rd_nxt_idx = rd_ptr_q[AW-1:0] + AW'(1);
  assign dout_o     = dout_q;
  assign count_o    = count_q;

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)
      count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      count_d = count_q - (AW+1)'(1);
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_q[AW-1:0]] <= din_i;
  end

  // Pointers, count and the registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        // Next head comes from RAM, or straight from din when the only
        // remaining entry is the one being written this cycle.
        if (count_q > (AW+1)'(1))
          dout_q <= mem[rd_nxt_idx];
        else if (push_ok)
          dout_q <= din_i;
      end else if (push_ok && empty_o) begin
        dout_q <= din_i;
      end
    end
  end

endmodule

// File: rtl/piso_word_serializer.sv
// Parallel-in serial-out word serializer feeding a SIPO deserializer.
// Words are queued in a FIFO, then shifted out LSB first while 'start'
// is high for exactly WIDTH cycles, followed by GAP+1 low cycles.
module piso_word_serializer
  import vmm_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          so,
  output logic                          start,
  output logic                          busy,
  output logic                          word_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  ser_state_t       state_q;
  logic [WIDTH-2:0] shreg_q;      // bits not yet driven; next bit at [0]
  logic [BW-1:0]    bitcnt_q;
  logic [GW-1:0]    gapcnt_q;
  logic             so_q, start_q, done_q;

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full, fifo_empty, fifo_pop;

  assign in_ready  = !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign so        = so_q;
  assign start     = start_q;
  assign word_done = done_q;

  sync_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid && in_ready),
    .din_i   (in_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Serializer FSM: load a word, shift it out, then hold start low for GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      so_q     <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg_q  <= fifo_dout[WIDTH-1:1];
            so_q     <= fifo_dout[0];
            start_q  <= 1'b1;
            bitcnt_q <= BW'(1);
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bitcnt_q == BW'(WIDTH)) begin
            // Last bit has been on 'so' for a full cycle: close the frame.
            start_q  <= 1'b0;
            so_q     <= 1'b0;
            done_q   <= 1'b1;
            gapcnt_q <= GW'(1);
            state_q  <= ST_GAP;
          end else begin
            so_q     <= shreg_q[0];
            shreg_q  <= shreg_q >> 1;
            bitcnt_q <= bitcnt_q + BW'(1);
          end
        end
        ST_GAP: begin
          if (gapcnt_q == GW'(GAP))
            state_q <= ST_IDLE;
          else
            gapcnt_q <= gapcnt_q + GW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_word_serializer.sv
// Directed bench: a GAP=1 instance and a GAP=3 instance, each observed by
// a behavioural SIPO that rebuilds words from so/start.
module tb_piso_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] in_data0, in_data1;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic        so0, so1, start0, start1, busy0, busy1, done0, done1;
  logic [2:0]  cnt0, cnt1;

  piso_word_serializer #(.WIDTH(32), .FIFO_DEPTH(4), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .so(so0), .start(start0), .busy(busy0),
    .word_done(done0), .fifo_count(cnt0)
  );

  piso_word_serializer #(.WIDTH(32), .FIFO_DEPTH(4), .GAP(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .so(so1), .start(start1), .busy(busy1),
    .word_done(done1), .fifo_count(cnt1)
  );

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  // ---------------- SIPO model / frame monitor (negedge sampling) -------
  logic        st_w [2];
  logic        so_w [2];
  logic        wd_w [2];
  assign st_w[0] = start0;  assign st_w[1] = start1;
  assign so_w[0] = so0;     assign so_w[1] = so1;
  assign wd_w[0] = done0;   assign wd_w[1] = done1;

  int          hi_run   [2] = '{0, 0};
  int          lo_run   [2] = '{0, 0};
  int          flips    [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          rx_n     [2] = '{0, 0};
  logic        prev_st  [2] = '{1'b0, 1'b0};
  logic        prev_so  [2] = '{1'b0, 1'b0};
  logic        seen_fall[2] = '{1'b0, 1'b0};
  logic        gap_chk  [2] = '{1'b0, 1'b0};
  logic [31:0] sr       [2];
  logic [7:0]  first8   [2];
  logic [31:0] rx_buf   [2][64];
  int          exp_gap  [2] = '{2, 4};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        hi_run[d]    = 0;
        lo_run[d]    = 0;
        flips[d]     = 0;
        prev_st[d]   = 1'b0;
        seen_fall[d] = 1'b0;
      end else begin
        if (wd_w[d]) begin
          done_cnt[d]++;
          chk("done_not_with_start", {31'd0, st_w[d]}, 32'd0);
        end
        if (st_w[d]) begin
          if (!prev_st[d]) begin
            if (gap_chk[d] && seen_fall[d])
              chk("start_low_cycles", lo_run[d], exp_gap[d]);
            hi_run[d] = 0;
            flips[d]  = 0;
          end else if (so_w[d] != prev_so[d]) begin
            flips[d]++;
          end
          sr[d] = {so_w[d], sr[d][31:1]};
          hi_run[d]++;
          if (hi_run[d] == 8) first8[d] = sr[d][31:24];
          if (hi_run[d] == 32 && rx_n[d] < 64) begin
            rx_buf[d][rx_n[d]] = sr[d];
            rx_n[d]++;
          end
        end else begin
          if (prev_st[d]) begin
            chk("start_high_cycles", hi_run[d], 32);
            if (d == 1) chk("so_const_in_frame", flips[d], 0);
            seen_fall[d] = gap_chk[d];
            lo_run[d]    = 0;
          end
          lo_run[d]++;
        end
        prev_st[d] = st_w[d];
        prev_so[d] = so_w[d];
      end
    end
  end

  // ---------------- helpers ---------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] w);
    in_data0  = w;
    in_valid0 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int n0, input int maxc);
    int k = 0;
    while (done_cnt[d] == n0 && k < maxc) begin
      step();
      k++;
    end
    chk("word_done_seen", {31'd0, done_cnt[d] != n0}, 32'd1);
  endtask

  task automatic wait_rx(input int d, input int target, input int maxc);
    int k = 0;
    while (rx_n[d] < target && k < maxc) begin
      step();
      k++;
    end
    chk("words_received", rx_n[d], target);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [7:0]  exp_first8;
    logic [31:0] exp_po;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [4];
    logic [31:0] w2  [6];
    int          base, d0, k, guard, viol_st, viol_so, viol_wd, viol_bz, viol_rdy;
    logic        saw_nr;

    tbl[0] = '{32'hA5A50F0F, 8'h0F, 32'hA5A50F0F};
    tbl[1] = '{32'h80000001, 8'h01, 32'h80000001};
    tbl[2] = '{32'h12345678, 8'h78, 32'h12345678};
    tbl[3] = '{32'hFFFF0000, 8'h00, 32'hFFFF0000};
    w2 = '{32'h11111111, 32'h22222222, 32'hDEADBEEF,
           32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};

    rst_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_data0 = '0; in_data1 = '0;
    repeat (3) step();
    chk("rst_so", {31'd0, so0}, 32'd0);
    chk("rst_start", {31'd0, start0}, 32'd0);
    chk("rst_word_done", {31'd0, done0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_fifo_count", {29'd0, cnt0}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    rst_n = 1'b1;
    step();

    // Single words into an idle block: latency, bit order, one word_done.
    for (int i = 0; i < 4; i++) begin
      base = rx_n[0];
      d0   = done_cnt[0];
      chk("ready_when_idle", {31'd0, in_ready0}, 32'd1);
      push0(tbl[i].din);
      step();
      chk("start_low_after_accept", {31'd0, start0}, 32'd0);
      chk("count_after_accept", {29'd0, cnt0}, 32'd1);
      step();
      chk("start_high_next_edge", {31'd0, start0}, 32'd1);
      wait_done(0, d0, 60);
      repeat (3) step();
      chk("done_pulses", done_cnt[0] - d0, 32'd1);
      chk("first8_so_bits", {24'd0, first8[0]}, {24'd0, tbl[i].exp_first8});
      chk("sipo_po", rx_buf[0][base], tbl[i].exp_po);
      chk("busy_after_word", {31'd0, busy0}, 32'd0);
    end

    // Six words with in_valid held high: back-pressure, order, gap.
    gap_chk[0] = 1'b1;
    base   = rx_n[0];
    saw_nr = 1'b0;
    k      = 0;
    guard  = 0;
    in_valid0 = 1'b1;
    while (k < 6 && guard < 400) begin
      in_data0 = w2[k];
      if (in_ready0) begin
        @(posedge clk);
        #1;
        k++;
      end else begin
        if (!saw_nr) begin
          saw_nr = 1'b1;
          chk("count_when_not_ready", {29'd0, cnt0}, 32'd4);
        end
        @(posedge clk);
        #1;
      end
      guard++;
    end
    in_valid0 = 1'b0;
    chk("all_six_accepted", k, 6);
    chk("in_ready_dropped", {31'd0, saw_nr}, 32'd1);
    wait_rx(0, base + 6, 500);
    for (int i = 0; i < 6; i++)
      chk("burst_word_order", rx_buf[0][base+i], w2[i]);
    repeat (4) step();
    gap_chk[0] = 1'b0;

    // Push and pop on the same edge with two words queued.
    base = rx_n[0];
    d0   = done_cnt[0];
    push0(32'hAAAA0001);
    push0(32'hBBBB0002);
    push0(32'hCCCC0003);
    chk("count_two_queued", {29'd0, cnt0}, 32'd2);
    wait_done(0, d0, 60);
    @(posedge clk);
    #1;
    chk("count_before_pushpop", {29'd0, cnt0}, 32'd2);
    push0(32'hDDDD0004);
    chk("count_after_pushpop", {29'd0, cnt0}, 32'd2);
    chk("start_on_pushpop_edge", {31'd0, start0}, 32'd1);
    wait_rx(0, base + 4, 300);
    chk("pushpop_w0", rx_buf[0][base+0], 32'hAAAA0001);
    chk("pushpop_w1", rx_buf[0][base+1], 32'hBBBB0002);
    chk("pushpop_w2", rx_buf[0][base+2], 32'hCCCC0003);
    chk("pushpop_w3", rx_buf[0][base+3], 32'hDDDD0004);
    repeat (4) step();

    // Asynchronous reset in the middle of a frame with two words queued.
    push0(32'hFFFFFFFF);
    push0(32'h0F0F0F0F);
    push0(32'hF0F0F0F0);
    k = 0;
    while (hi_run[0] != 17 && k < 100) begin
      step();
      k++;
    end
    chk("reached_bit17", hi_run[0], 17);
    chk("queued_before_reset", {29'd0, cnt0}, 32'd2);
    base = rx_n[0];
    d0   = done_cnt[0];
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_start", {31'd0, start0}, 32'd0);
    chk("rst_mid_so", {31'd0, so0}, 32'd0);
    chk("rst_mid_count", {29'd0, cnt0}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("no_done_after_reset", done_cnt[0] - d0, 32'd0);
    chk("no_word_after_reset", rx_n[0] - base, 32'd0);
    chk("idle_after_reset", {31'd0, start0}, 32'd0);
    d0 = done_cnt[0];
    push0(32'h12345678);
    wait_done(0, d0, 60);
    step();
    chk("post_reset_word", rx_buf[0][base], 32'h12345678);

    // GAP=3 instance: all-zeros then all-ones, back to back.
    gap_chk[1] = 1'b1;
    base = rx_n[1];
    in_data1 = 32'h00000000; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_data1 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    wait_rx(1, base + 2, 200);
    chk("gap3_word0", rx_buf[1][base+0], 32'h00000000);
    chk("gap3_word1", rx_buf[1][base+1], 32'hFFFFFFFF);
    repeat (6) step();
    chk("gap3_count_empty", {29'd0, cnt1}, 32'd0);
    gap_chk[1] = 1'b0;

    // No input for 100 cycles: everything quiet.
    repeat (5) step();
    viol_st = 0; viol_so = 0; viol_wd = 0; viol_bz = 0; viol_rdy = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (start0 || start1) viol_st++;
      if (so0 || so1) viol_so++;
      if (done0 || done1) viol_wd++;
      if (busy0 || busy1) viol_bz++;
      if (!in_ready0 || !in_ready1) viol_rdy++;
    end
    chk("quiet_start_cycles", viol_st, 0);
    chk("quiet_so_cycles", viol_so, 0);
    chk("quiet_done_cycles", viol_wd, 0);
    chk("quiet_busy_cycles", viol_bz, 0);
    chk("quiet_not_ready_cycles", viol_rdy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
